// File: rtl/div_if.sv
// Handshake bundle between the EX stage (master) and the multi-cycle divider (slave).
interface div_if #(
  parameter int DATA_W = 32
);
  logic              div_flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        div_op;
  logic [DATA_W-1:0] div_src1;
  logic [DATA_W-1:0] div_src2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] div_result;
  logic              busy;

  modport master (
    output div_flush, in_valid, div_op, div_src1, div_src2, out_ready,
    input  in_ready, out_valid, div_result, busy
  );

  modport slave (
    input  div_flush, in_valid, div_op, div_src1, div_src2, out_ready,
    output in_ready, out_valid, div_result, busy
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for div.w/mod.w/div.wu/mod.wu: one quotient bit per
// clock on operand magnitudes, sign-corrected into a registered result.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic resetn,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              is_div_q,   is_div_d;
  logic              neg_quo_q,  neg_quo_d;
  logic              neg_rem_q,  neg_rem_d;
  logic              dvs_zero_q, dvs_zero_d;
  logic [DATA_W-1:0] dvd_q,      dvd_d;
  logic [DATA_W-1:0] dvs_q,      dvs_d;
  logic [DATA_W-1:0] src1_q,     src1_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic [DATA_W:0]   rem_q,      rem_d;

  logic              op_signed;
  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W+1:0] trial;
  logic              q_bit;
  logic [DATA_W:0]   rem_iter;
  logic [DATA_W-1:0] quo_iter;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] final_val;

  assign op_signed = bus.div_op[0] | bus.div_op[1];
  assign src1_neg  = op_signed & bus.div_src1[DATA_W-1];
  assign src2_neg  = op_signed & bus.div_src2[DATA_W-1];
  // Negating 0x80000000 yields 0x80000000, which is the correct magnitude read unsigned.
  assign mag1      = src1_neg ? -bus.div_src1 : bus.div_src1;
  assign mag2      = src2_neg ? -bus.div_src2 : bus.div_src2;

  // One restoring step; the extra top bit of trial is the borrow that rejects the subtract.
  always_comb begin
    trial    = {rem_q, dvd_q[DATA_W-1]} - {2'b00, dvs_q};
    q_bit    = ~trial[DATA_W+1];
    rem_iter = q_bit ? trial[DATA_W:0] : {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    quo_iter = {dvd_q[DATA_W-2:0], q_bit};
    quo_fix  = neg_quo_q ? -quo_iter : quo_iter;
    rem_fix  = neg_rem_q ? -rem_iter[DATA_W-1:0] : rem_iter[DATA_W-1:0];
    if (dvs_zero_q) final_val = is_div_q ? '1 : src1_q;
    else            final_val = is_div_q ? quo_fix : rem_fix;
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dvs_zero_d = dvs_zero_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    src1_d     = src1_q;
    result_d   = result_q;
    rem_d      = rem_q;

    if (bus.div_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_d    = S_CALC;
            cnt_d      = '0;
            is_div_d   = (bus.div_op[0] | bus.div_op[2]) & ~(bus.div_op[1] | bus.div_op[3]);
            neg_quo_d  = src1_neg ^ src2_neg;
            neg_rem_d  = src1_neg;
            dvs_zero_d = (bus.div_src2 == '0);
            dvd_d      = mag1;
            dvs_d      = mag2;
            src1_d     = bus.div_src1;
            rem_d      = '0;
          end
        end
        S_CALC: begin
          rem_d = rem_iter;
          dvd_d = quo_iter;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            result_d = final_val;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      src1_q     <= '0;
      result_q   <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dvs_zero_q <= dvs_zero_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      src1_q     <= src1_d;
      result_q   <= result_d;
      rem_q      <= rem_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.div_result = result_q;

endmodule
